// File: rtl/exec_ctrl_alu.sv
// exec_ctrl_alu -- execute-side datapath core of the 5-stage MIPS pipeline.
//
// Contents:
//   - Instruction decoder: combinational; produces the ALU operation and the control
//     signals for the instruction in IF_ID.
//   - 32-bit ALU: purely combinational; operands are the forwarded ID_EX values.
//   - Clock divider: free-running; used for slow display scanning.
//
// Parameters:
//   WIDTH    ALU datapath width (default 32).
//   DIV_CNT  Clk cycles per half-period of clk_div (>= 1).
//
// Optional feature (macro ALU_OVERFLOW_EN), when defined:
//   - Adds the output port overflow, the signed overflow of ADD/SUB.
//   - Decodes addu/subu.
//
// Ports:
//   Clk, Clr    clock; asynchronous active-low reset (divider only)
//   inst        instruction to decode
//   input1/2    ALU operands (input2[4:0] is the shift amount)
//   alu_op      ALU operation select
//   AluCtrl     decoded ALU operation for inst
//   Reg_Dst, ALU_Src1, ALU_Src2, Mem_Write, Mem_Read, MemtoReg, Reg_Write, Halt
//               decoded control signals
//   result      ALU result
//   zero        result == 0
//   clk_div     divided clock, period 2*DIV_CNT Clk cycles
//   overflow    signed ADD/SUB overflow (ALU_OVERFLOW_EN only)
module exec_ctrl_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DIV_CNT = 25000000
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [31:0]      inst,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       alu_op,
  output logic [3:0]       AluCtrl,
  output logic             Reg_Dst,
  output logic             ALU_Src1,
  output logic             ALU_Src2,
  output logic             Mem_Write,
  output logic             Mem_Read,
  output logic             MemtoReg,
  output logic             Reg_Write,
  output logic             Halt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             clk_div
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_SLL = 4'b1000,
    OP_SRL = 4'b1001,
    OP_NOR = 4'b1100
  } alu_op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_HALT  = 6'b111111;

  // ---------------------------------------------------------------- decoder
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       r_hit;
  logic       r_shift;
  alu_op_e    r_op;

  assign opcode = inst[31:26];
  assign funct  = inst[5:0];

  // R-type funct lookup kept separate so the opcode case stays flat.
  always_comb begin
    r_hit   = 1'b0;
    r_shift = 1'b0;
    r_op    = OP_ADD;
    case (funct)
      6'b100000: begin r_hit = 1'b1; r_op = OP_ADD; end
      6'b100010: begin r_hit = 1'b1; r_op = OP_SUB; end
      6'b100100: begin r_hit = 1'b1; r_op = OP_AND; end
      6'b100101: begin r_hit = 1'b1; r_op = OP_OR;  end
      6'b100110: begin r_hit = 1'b1; r_op = OP_XOR; end
      6'b100111: begin r_hit = 1'b1; r_op = OP_NOR; end
      6'b101010: begin r_hit = 1'b1; r_op = OP_SLT; end
      6'b000000: begin r_hit = 1'b1; r_shift = 1'b1; r_op = OP_SLL; end
      6'b000010: begin r_hit = 1'b1; r_shift = 1'b1; r_op = OP_SRL; end
`ifdef ALU_OVERFLOW_EN
      6'b100001: begin r_hit = 1'b1; r_op = OP_ADD; end
      6'b100011: begin r_hit = 1'b1; r_op = OP_SUB; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    AluCtrl   = OP_ADD;
    Reg_Dst   = 1'b0;
    ALU_Src1  = 1'b0;
    ALU_Src2  = 1'b0;
    Mem_Write = 1'b0;
    Mem_Read  = 1'b0;
    MemtoReg  = 1'b0;
    Reg_Write = 1'b0;
    Halt      = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        // The all-zero word is a NOP even though it looks like "sll r0,r0,0".
        if ((inst != '0) && r_hit) begin
          AluCtrl   = r_op;
          Reg_Dst   = 1'b1;
          Reg_Write = 1'b1;
          ALU_Src1  = r_shift;
        end
      end
      OPC_ADDI: begin
        AluCtrl   = OP_ADD;
        ALU_Src2  = 1'b1;
        Reg_Write = 1'b1;
      end
      OPC_SLTI: begin
        AluCtrl   = OP_SLT;
        ALU_Src2  = 1'b1;
        Reg_Write = 1'b1;
      end
      OPC_LW: begin
        AluCtrl   = OP_ADD;
        ALU_Src2  = 1'b1;
        Mem_Read  = 1'b1;
        MemtoReg  = 1'b1;
        Reg_Write = 1'b1;
      end
      OPC_SW: begin
        AluCtrl   = OP_ADD;
        ALU_Src2  = 1'b1;
        Mem_Write = 1'b1;
      end
      OPC_BEQ, OPC_BNE: AluCtrl = OP_SUB;
      OPC_J:            AluCtrl = OP_ADD;
      OPC_HALT:         Halt    = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------- ALU
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;

  assign sum  = input1 + input2;
  assign diff = input1 - input2;
  assign slt  = $signed(input1) < $signed(input2);

  always_comb begin
    result = '0;
    case (alu_op)
      OP_AND:  result = input1 & input2;
      OP_OR:   result = input1 | input2;
      OP_ADD:  result = sum;
      OP_XOR:  result = input1 ^ input2;
      OP_SUB:  result = diff;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
      OP_SLL:  result = input1 << input2[4:0];
      OP_SRL:  result = input1 >> input2[4:0];
      OP_NOR:  result = ~(input1 | input2);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef ALU_OVERFLOW_EN
  // Overflow iff the operands (B inverted for SUB) share a sign that the result lacks.
  always_comb begin
    overflow = 1'b0;
    case (alu_op)
      OP_ADD: overflow = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                         (sum[WIDTH-1] != input1[WIDTH-1]);
      OP_SUB: overflow = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                         (diff[WIDTH-1] != input1[WIDTH-1]);
      default: overflow = 1'b0;
    endcase
  end
`endif

  // ---------------------------------------------------------------- divider
  localparam int unsigned CW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_q, div_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    div_d = div_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      div_d = ~div_q;
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign clk_div = div_q;

endmodule

// File: tb/tb_exec_ctrl_alu.sv
// Bench for exec_ctrl_alu (DIV_CNT=3). Directed vectors with literal expectations,
// then randomized instructions/operands checked every cycle against a reference model.
module tb_exec_ctrl_alu;

  localparam int unsigned DC = 3;

  logic        Clk = 1'b0;
  logic        Clr;
  logic [31:0] inst;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [3:0]  alu_op;
  logic [3:0]  AluCtrl;
  logic        Reg_Dst, ALU_Src1, ALU_Src2, Mem_Write, Mem_Read, MemtoReg, Reg_Write, Halt;
  logic [31:0] result;
  logic        zero;
  logic        clk_div;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b0;
  int n_edges;

  always #5 Clk = ~Clk;

  exec_ctrl_alu #(.WIDTH(32), .DIV_CNT(DC)) dut (
    .Clk(Clk), .Clr(Clr), .inst(inst), .input1(input1), .input2(input2), .alu_op(alu_op),
    .AluCtrl(AluCtrl), .Reg_Dst(Reg_Dst), .ALU_Src1(ALU_Src1), .ALU_Src2(ALU_Src2),
    .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .MemtoReg(MemtoReg), .Reg_Write(Reg_Write),
    .Halt(Halt), .result(result), .zero(zero), .clk_div(clk_div)
`ifdef ALU_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  // {AluCtrl, Reg_Dst, ALU_Src1, ALU_Src2, Mem_Write, Mem_Read, MemtoReg, Reg_Write, Halt}
  logic [11:0] dut_dec;
  assign dut_dec = {AluCtrl, Reg_Dst, ALU_Src1, ALU_Src2, Mem_Write, Mem_Read,
                    MemtoReg, Reg_Write, Halt};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [4:0] sh = b[4:0];
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return 32'(longint'(a) + longint'(b));
      4'd3:  return a ^ b;
      4'd6:  return 32'(longint'(a) - longint'(b));
      4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  return 32'(longint'(a) * (longint'(1) << sh));
      4'd9:  return 32'(longint'(a) / (longint'(1) << sh));
      4'd12: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ovf_ref(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    longint r;
    if (op == 4'd2)      r = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'd6) r = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic logic [11:0] dec_ref(input logic [31:0] i);
    logic [5:0] op = i[31:26];
    logic [5:0] fn = i[5:0];
    if (i == 32'h0) return {4'd2, 8'b0000_0000};
    case (op)
      6'd0: case (fn)
        6'd32:   return {4'd2,  8'b1000_0010};
        6'd34:   return {4'd6,  8'b1000_0010};
        6'd36:   return {4'd0,  8'b1000_0010};
        6'd37:   return {4'd1,  8'b1000_0010};
        6'd38:   return {4'd3,  8'b1000_0010};
        6'd39:   return {4'd12, 8'b1000_0010};
        6'd42:   return {4'd7,  8'b1000_0010};
        6'd0:    return {4'd8,  8'b1100_0010};
        6'd2:    return {4'd9,  8'b1100_0010};
`ifdef ALU_OVERFLOW_EN
        6'd33:   return {4'd2,  8'b1000_0010};
        6'd35:   return {4'd6,  8'b1000_0010};
`endif
        default: return {4'd2,  8'b0000_0000};
      endcase
      6'd8:    return {4'd2, 8'b0010_0010};
      6'd10:   return {4'd7, 8'b0010_0010};
      6'd35:   return {4'd2, 8'b0010_1110};
      6'd43:   return {4'd2, 8'b0011_0000};
      6'd4:    return {4'd6, 8'b0000_0000};
      6'd5:    return {4'd6, 8'b0000_0000};
      6'd2:    return {4'd2, 8'b0000_0000};
      6'd63:   return {4'd2, 8'b0000_0001};
      default: return {4'd2, 8'b0000_0000};
    endcase
  endfunction

  // Divider model: rising edges since reset released; clk_div is high on odd half-periods.
  always @(posedge Clk or negedge Clr) begin
    if (!Clr) n_edges <= 0;
    else      n_edges <= n_edges + 1;
  end

  always @(negedge Clk) begin
    if (run_cmp) begin
      chk("dec", {20'd0, dut_dec}, {20'd0, dec_ref(inst)});
      chk("result", result, alu_ref(alu_op, input1, input2));
      chk("zero", {31'd0, zero}, {31'd0, alu_ref(alu_op, input1, input2) == 32'd0});
      chk("clk_div", {31'd0, clk_div}, 32'((n_edges / DC) % 2));
`ifdef ALU_OVERFLOW_EN
      chk("overflow", {31'd0, overflow}, {31'd0, ovf_ref(alu_op, input1, input2)});
`endif
    end
  end

  // ------------------------------------------------------------------ stimulus
  task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op = op; input1 = a; input2 = b;
    #1;
  endtask

  task automatic set_inst(input logic [31:0] i);
    inst = i;
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [5:0] opcs [12] = '{6'd0, 6'd0, 6'd0, 6'd8, 6'd10, 6'd35, 6'd43, 6'd4, 6'd5,
                              6'd2, 6'd63, 6'd17};
    logic [5:0] fns [12]  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd0,
                              6'd2, 6'd33, 6'd35, 6'd1};
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 15) == 0) return 32'h0;
    w[31:26] = opcs[$urandom_range(0, 11)];
    if ($urandom_range(0, 9) == 0) w[31:26] = 6'($urandom);
    w[5:0] = fns[$urandom_range(0, 11)];
    return w;
  endfunction

  bit exp_div [12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};

  initial begin
    Clr = 1'b0; inst = '0; input1 = '0; input2 = '0; alu_op = '0;
    #12;
    chk("reset_clk_div", {31'd0, clk_div}, 32'd0);

    // ALU literal vectors
    set_alu(4'd2, 32'd7, 32'd5);          chk("add_7_5", result, 32'd12);
                                          chk("add_7_5_zero", {31'd0, zero}, 32'd0);
    set_alu(4'd6, 32'd5, 32'd5);          chk("sub_5_5", result, 32'd0);
                                          chk("sub_5_5_zero", {31'd0, zero}, 32'd1);
    set_alu(4'd2, 32'hFFFF_FFFF, 32'd1);  chk("add_wrap", result, 32'd0);
    set_alu(4'd7, 32'hFFFF_FFFF, 32'd1);  chk("slt_m1_1", result, 32'd1);
    set_alu(4'd7, 32'd1, 32'hFFFF_FFFF);  chk("slt_1_m1", result, 32'd0);
    set_alu(4'd8, 32'h1, 32'd31);         chk("sll_31", result, 32'h8000_0000);
    set_alu(4'd9, 32'h8000_0000, 32'd4);  chk("srl_4", result, 32'h0800_0000);
    set_alu(4'd12, 32'h0, 32'h0);         chk("nor_0_0", result, 32'hFFFF_FFFF);
    set_alu(4'd4, 32'h1234, 32'h5678);    chk("unlisted_op", result, 32'd0);
`ifdef ALU_OVERFLOW_EN
    set_alu(4'd2, 32'h7FFF_FFFF, 32'd1);  chk("ovf_add", {31'd0, overflow}, 32'd1);
    set_alu(4'd6, 32'h8000_0000, 32'd1);  chk("ovf_sub", {31'd0, overflow}, 32'd1);
    set_alu(4'd2, 32'd2, 32'd3);          chk("ovf_none", {31'd0, overflow}, 32'd0);
`endif

    // Decoder literal vectors
    set_inst(32'h8C02_0004); chk("dec_lw",   {20'd0, dut_dec}, {20'd0, 4'd2, 8'b0010_1110});
    set_inst(32'hAC02_0004); chk("dec_sw",   {20'd0, dut_dec}, {20'd0, 4'd2, 8'b0011_0000});
    set_inst(32'h0043_0820); chk("dec_add",  {20'd0, dut_dec}, {20'd0, 4'd2, 8'b1000_0010});
    set_inst(32'h0000_0000); chk("dec_nop",  {20'd0, dut_dec}, {20'd0, 4'd2, 8'b0000_0000});
    set_inst(32'h1043_0003); chk("dec_beq",  {20'd0, dut_dec}, {20'd0, 4'd6, 8'b0000_0000});
    set_inst(32'hFC00_0000); chk("dec_halt", {20'd0, dut_dec}, {20'd0, 4'd2, 8'b0000_0001});
    set_inst(32'h4400_0000); chk("dec_unk",  {20'd0, dut_dec}, {20'd0, 4'd2, 8'b0000_0000});
    set_inst(32'h0002_0880); chk("dec_sll",  {20'd0, dut_dec}, {20'd0, 4'd8, 8'b1100_0010});

    // Divider: release, then literal toggle pattern over 12 edges
    @(negedge Clk);
    Clr = 1'b1;
    run_cmp = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      chk("div_pattern", {31'd0, clk_div}, {31'd0, exp_div[k]});
    end

    // Async clear while clk_div is high
    for (int k = 0; k < 10 && clk_div !== 1'b1; k++) @(negedge Clk);
    chk("div_high_before_clr", {31'd0, clk_div}, 32'd1);
    #2 Clr = 1'b0;
    #1 chk("clr_async", {31'd0, clk_div}, 32'd0);
    @(negedge Clk);
    Clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("div_after_release", {31'd0, clk_div}, (k == 2) ? 32'd1 : 32'd0);
    end

    // Randomized phase, checked every cycle by the compare process
    for (int k = 0; k < 600; k++) begin
      @(posedge Clk);
      #1;
      inst   = rand_inst();
      alu_op = 4'($urandom_range(0, 15));
      input1 = rand_word();
      input2 = ($urandom_range(0, 3) == 0) ? input1 : rand_word();
      Clr    = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
    end
    @(negedge Clk);
    run_cmp = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
